// File: rtl/cellrv32_vrf_wr_arbiter_pkg.sv
// Shared types for the VRF write-port arbiter.
package cellrv32_package;

  typedef enum logic [1:0] {
    VWR_NONE,
    VWR_EX,
    VWR_LD,
    VWR_BOTH
  } vrf_wr_src_e;

endpackage

// File: rtl/cellrv32_vrf_wr_grant.sv
// Grant decision for the VRF write port: EX/load arbitration with a load starvation bound.
// Same-register, disjoint-mask merging is enabled by defining CELLRV32_VRF_WR_MERGE_EN.
module cellrv32_vrf_wr_grant
  import cellrv32_package::*;
#(
  parameter int unsigned STARVE_MAX = 3
`ifdef CELLRV32_VRF_WR_MERGE_EN
  ,
  parameter int unsigned AW       = 5,
  parameter int unsigned ELEMENTS = 4
`endif
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                ex_valid_i,
  input  logic                ld_valid_i,
`ifdef CELLRV32_VRF_WR_MERGE_EN
  input  logic [AW-1:0]       ex_addr_i,
  input  logic [ELEMENTS-1:0] ex_mask_i,
  input  logic [AW-1:0]       ld_addr_i,
  input  logic [ELEMENTS-1:0] ld_mask_i,
`endif
  output logic                ex_ready_o,
  output logic                ld_ready_o,
  output vrf_wr_src_e         src_o
);

  localparam int unsigned WaitW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_MAX);

  logic [WaitW-1:0] r_ld_wait;
  logic [WaitW-1:0] w_ld_wait_d;
  logic             w_merge;
  logic             w_ld_due;
  logic             w_ex_gnt;
  logic             w_ld_gnt;

`ifdef CELLRV32_VRF_WR_MERGE_EN
  assign w_merge = ex_valid_i & ld_valid_i & (ex_addr_i == ld_addr_i) & ~|(ex_mask_i & ld_mask_i);
`else
  assign w_merge = 1'b0;
`endif

  // The counter saturates at WaitMax, so equality is the same as reaching the bound.
  assign w_ld_due = (r_ld_wait == WaitMax);

  always_comb begin
    w_ex_gnt    = 1'b0;
    w_ld_gnt    = 1'b0;
    w_ld_wait_d = '0;
    if (rstn_i) begin
      if (ex_valid_i && ld_valid_i) begin
        if (w_merge) begin
          w_ex_gnt = 1'b1;
          w_ld_gnt = 1'b1;
        end else if (w_ld_due) begin
          w_ld_gnt = 1'b1;
        end else begin
          w_ex_gnt = 1'b1;
        end
      end else begin
        w_ex_gnt = ex_valid_i;
        w_ld_gnt = ld_valid_i;
      end

      if (ld_valid_i && !w_ld_gnt) begin
        w_ld_wait_d = (r_ld_wait != WaitMax) ? r_ld_wait + WaitW'(1) : r_ld_wait;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_ld_wait <= '0;
    end else begin
      r_ld_wait <= w_ld_wait_d;
    end
  end

  always_comb begin
    src_o = VWR_NONE;
    unique case ({w_ld_gnt, w_ex_gnt})
      2'b01:   src_o = VWR_EX;
      2'b10:   src_o = VWR_LD;
      2'b11:   src_o = VWR_BOTH;
      default: src_o = VWR_NONE;
    endcase
  end

  assign ex_ready_o = w_ex_gnt;
  assign ld_ready_o = w_ld_gnt;

endmodule

// File: rtl/cellrv32_vrf_wr_arbiter.sv
// VRF write-port scheduler: arbitrates EX vs load writes, registers the winner for one cycle
// and exports a pending-write bitmap. Define CELLRV32_VRF_WR_MERGE_EN to allow merged grants.
module cellrv32_vrf_wr_arbiter
  import cellrv32_package::*;
#(
  parameter int unsigned VREGS      = 32,
  parameter int unsigned ELEMENTS   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STARVE_MAX = 3,
  localparam int unsigned AW        = $clog2(VREGS)
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 ex_valid_i,
  output logic                                 ex_ready_o,
  input  logic [AW-1:0]                        ex_addr_i,
  input  logic [ELEMENTS-1:0]                  ex_mask_i,
  input  logic [ELEMENTS*DATA_WIDTH-1:0]       ex_data_i,
  input  logic                                 ld_valid_i,
  output logic                                 ld_ready_o,
  input  logic [AW-1:0]                        ld_addr_i,
  input  logic [ELEMENTS-1:0]                  ld_mask_i,
  input  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  ld_data_i,
  output logic [ELEMENTS-1:0]                  v_wr_en_o,
  output logic [AW-1:0]                        v_wr_addr_o,
  output logic [ELEMENTS*DATA_WIDTH-1:0]       v_wr_data_o,
  output logic [ELEMENTS-1:0]                  el_wr_en_o,
  output logic [AW-1:0]                        el_wr_addr_o,
  output logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  el_wr_data_o,
  output logic [VREGS-1:0]                     pend_o
);

  vrf_wr_src_e                           w_src;
  logic                                  w_ex_take;
  logic                                  w_ld_take;
  logic [ELEMENTS-1:0]                   r_v_en;
  logic [AW-1:0]                         r_v_addr;
  logic [ELEMENTS*DATA_WIDTH-1:0]        r_v_data;
  logic [ELEMENTS-1:0]                   r_el_en;
  logic [AW-1:0]                         r_el_addr;
  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]   r_el_data;
  logic [VREGS-1:0]                      w_pend;

  cellrv32_vrf_wr_grant #(
    .STARVE_MAX (STARVE_MAX)
`ifdef CELLRV32_VRF_WR_MERGE_EN
    ,
    .AW         (AW),
    .ELEMENTS   (ELEMENTS)
`endif
  ) u_grant (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .ex_valid_i (ex_valid_i),
    .ld_valid_i (ld_valid_i),
`ifdef CELLRV32_VRF_WR_MERGE_EN
    .ex_addr_i  (ex_addr_i),
    .ex_mask_i  (ex_mask_i),
    .ld_addr_i  (ld_addr_i),
    .ld_mask_i  (ld_mask_i),
`endif
    .ex_ready_o (ex_ready_o),
    .ld_ready_o (ld_ready_o),
    .src_o      (w_src)
  );

  assign w_ex_take = (w_src == VWR_EX) || (w_src == VWR_BOTH);
  assign w_ld_take = (w_src == VWR_LD) || (w_src == VWR_BOTH);

  // Ungranted sources drop their enable but keep address/data from the last write.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_v_en    <= '0;
      r_v_addr  <= '0;
      r_v_data  <= '0;
      r_el_en   <= '0;
      r_el_addr <= '0;
      r_el_data <= '0;
    end else begin
      r_v_en  <= w_ex_take ? ex_mask_i : '0;
      r_el_en <= w_ld_take ? ld_mask_i : '0;
      if (w_ex_take) begin
        r_v_addr <= ex_addr_i;
        r_v_data <= ex_data_i;
      end
      if (w_ld_take) begin
        r_el_addr <= ld_addr_i;
        r_el_data <= ld_data_i;
      end
    end
  end

  always_comb begin
    w_pend = '0;
    if (|r_v_en) begin
      w_pend[r_v_addr] = 1'b1;
    end
    if (|r_el_en) begin
      w_pend[r_el_addr] = 1'b1;
    end
  end

  assign v_wr_en_o    = r_v_en;
  assign v_wr_addr_o  = r_v_addr;
  assign v_wr_data_o  = r_v_data;
  assign el_wr_en_o   = r_el_en;
  assign el_wr_addr_o = r_el_addr;
  assign el_wr_data_o = r_el_data;
  assign pend_o       = w_pend;

endmodule

// File: tb/tb_cellrv32_vrf_wr_arbiter.sv
// Self-checking bench for cellrv32_vrf_wr_arbiter: two instances (STARVE_MAX 3 and 0) driven
// by the same stimulus and compared against a transaction-level reference model.
module tb_cellrv32_vrf_wr_arbiter;

  localparam int unsigned VREGS    = 32;
  localparam int unsigned ELEMENTS = 4;
  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 5;
`ifdef CELLRV32_VRF_WR_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rstn;
  logic                         ex_valid;
  logic                         ld_valid;
  logic [AW-1:0]                ex_addr;
  logic [AW-1:0]                ld_addr;
  logic [ELEMENTS-1:0]          ex_mask;
  logic [ELEMENTS-1:0]          ld_mask;
  logic [ELEMENTS*DW-1:0]       ex_data;
  logic [ELEMENTS-1:0][DW-1:0]  ld_data;

  logic                         ex_rdy  [2];
  logic                         ld_rdy  [2];
  logic [ELEMENTS-1:0]          v_en    [2];
  logic [ELEMENTS-1:0]          el_en   [2];
  logic [AW-1:0]                v_addr  [2];
  logic [AW-1:0]                el_addr [2];
  logic [ELEMENTS*DW-1:0]       v_data  [2];
  logic [ELEMENTS-1:0][DW-1:0]  el_data [2];
  logic [VREGS-1:0]             pend    [2];

  cellrv32_vrf_wr_arbiter #(
    .VREGS(VREGS), .ELEMENTS(ELEMENTS), .DATA_WIDTH(DW), .STARVE_MAX(3)
  ) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_rdy[0]), .ex_addr_i(ex_addr),
    .ex_mask_i(ex_mask), .ex_data_i(ex_data),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_rdy[0]), .ld_addr_i(ld_addr),
    .ld_mask_i(ld_mask), .ld_data_i(ld_data),
    .v_wr_en_o(v_en[0]), .v_wr_addr_o(v_addr[0]), .v_wr_data_o(v_data[0]),
    .el_wr_en_o(el_en[0]), .el_wr_addr_o(el_addr[0]), .el_wr_data_o(el_data[0]),
    .pend_o(pend[0])
  );

  cellrv32_vrf_wr_arbiter #(
    .VREGS(VREGS), .ELEMENTS(ELEMENTS), .DATA_WIDTH(DW), .STARVE_MAX(0)
  ) u_dut_s0 (
    .clk_i(clk), .rstn_i(rstn),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_rdy[1]), .ex_addr_i(ex_addr),
    .ex_mask_i(ex_mask), .ex_data_i(ex_data),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_rdy[1]), .ld_addr_i(ld_addr),
    .ld_mask_i(ld_mask), .ld_data_i(ld_data),
    .v_wr_en_o(v_en[1]), .v_wr_addr_o(v_addr[1]), .v_wr_data_o(v_data[1]),
    .el_wr_en_o(el_en[1]), .el_wr_addr_o(el_addr[1]), .el_wr_data_o(el_data[1]),
    .pend_o(pend[1])
  );

  // Reference model: expected VRF write visible in the output stage, per instance.
  int unsigned                  streak   [2];
  bit                           g_ex     [2];
  bit                           g_ld     [2];
  logic                         s_ex_rdy [2];
  logic                         s_ld_rdy [2];
  logic [ELEMENTS-1:0]          m_v_en   [2];
  logic [ELEMENTS-1:0]          m_el_en  [2];
  logic [AW-1:0]                m_v_addr [2];
  logic [AW-1:0]                m_el_addr[2];
  logic [ELEMENTS*DW-1:0]       m_v_data [2];
  logic [ELEMENTS-1:0][DW-1:0]  m_el_data[2];

  int n_cmp = 0;
  int n_err = 0;

  function automatic int unsigned smax(input int k);
    return (k == 0) ? 3 : 0;
  endfunction

  task automatic chk(input string tag, input int k, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s [starve=%0d] observed %h expected %h", tag, smax(k), obs, exp);
    end
  endtask

  task automatic predict();
    for (int k = 0; k < 2; k++) begin
      g_ex[k] = 1'b0;
      g_ld[k] = 1'b0;
      if (rstn) begin
        if (ex_valid && ld_valid) begin
          if (MERGE && (ex_addr == ld_addr) && ((ex_mask & ld_mask) == '0)) begin
            g_ex[k] = 1'b1;
            g_ld[k] = 1'b1;
          end else if (streak[k] >= smax(k)) begin
            g_ld[k] = 1'b1;
          end else begin
            g_ex[k] = 1'b1;
          end
        end else begin
          g_ex[k] = ex_valid;
          g_ld[k] = ld_valid;
        end
      end
    end
  endtask

  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        streak[k]    = 0;
        m_v_en[k]    = '0;
        m_v_addr[k]  = '0;
        m_v_data[k]  = '0;
        m_el_en[k]   = '0;
        m_el_addr[k] = '0;
        m_el_data[k] = '0;
      end else begin
        m_v_en[k]  = g_ex[k] ? ex_mask : '0;
        m_el_en[k] = g_ld[k] ? ld_mask : '0;
        if (g_ex[k]) begin
          m_v_addr[k] = ex_addr;
          m_v_data[k] = ex_data;
        end
        if (g_ld[k]) begin
          m_el_addr[k] = ld_addr;
          m_el_data[k] = ld_data;
        end
        if (ld_valid && !g_ld[k]) streak[k] = (streak[k] < smax(k)) ? streak[k] + 1 : streak[k];
        else streak[k] = 0;
      end
    end
  endtask

  function automatic logic [VREGS-1:0] exp_pend(input int k);
    logic [VREGS-1:0] p;
    p = '0;
    if (m_v_en[k] != '0) p[m_v_addr[k]] = 1'b1;
    if (m_el_en[k] != '0) p[m_el_addr[k]] = 1'b1;
    return p;
  endfunction

  // One clock: check readies before the edge, then the output stage just after it.
  task automatic step(input string tag);
    #1;
    predict();
    for (int k = 0; k < 2; k++) begin
      s_ex_rdy[k] = ex_rdy[k];
      s_ld_rdy[k] = ld_rdy[k];
      chk({tag, "/ex_ready"}, k, 128'(ex_rdy[k]), 128'(g_ex[k]));
      chk({tag, "/ld_ready"}, k, 128'(ld_rdy[k]), 128'(g_ld[k]));
    end
    @(posedge clk);
    #1;
    commit();
    for (int k = 0; k < 2; k++) begin
      chk({tag, "/v_wr_en"}, k, 128'(v_en[k]), 128'(m_v_en[k]));
      chk({tag, "/v_wr_addr"}, k, 128'(v_addr[k]), 128'(m_v_addr[k]));
      chk({tag, "/v_wr_data"}, k, 128'(v_data[k]), 128'(m_v_data[k]));
      chk({tag, "/el_wr_en"}, k, 128'(el_en[k]), 128'(m_el_en[k]));
      chk({tag, "/el_wr_addr"}, k, 128'(el_addr[k]), 128'(m_el_addr[k]));
      chk({tag, "/el_wr_data"}, k, 128'(el_data[k]), 128'(m_el_data[k]));
      chk({tag, "/pend"}, k, 128'(pend[k]), 128'(exp_pend(k)));
    end
  endtask

  initial begin
    int ld_cnt0;
    int ld_cnt1;
    int ex_cnt0;
    for (int k = 0; k < 2; k++) begin
      streak[k]    = 0;
      m_v_en[k]    = '0;
      m_v_addr[k]  = '0;
      m_v_data[k]  = '0;
      m_el_en[k]   = '0;
      m_el_addr[k] = '0;
      m_el_data[k] = '0;
    end

    // Reset with both requesters valid: readies must stay low.
    rstn     = 1'b0;
    ex_valid = 1'b1;
    ld_valid = 1'b1;
    ex_addr  = 5'd3;
    ld_addr  = 5'd4;
    ex_mask  = 4'hf;
    ld_mask  = 4'hf;
    ex_data  = {$urandom, $urandom, $urandom, $urandom};
    ld_data  = {$urandom, $urandom, $urandom, $urandom};
    step("reset");
    step("reset");
    chk("reset_pend_zero", 0, 128'(pend[0]), 128'(0));

    // EX-only write to register 5.
    rstn     = 1'b1;
    ld_valid = 1'b0;
    ex_addr  = 5'd5;
    ex_mask  = 4'b1111;
    ex_data  = {32'h44, 32'h33, 32'h22, 32'h11};
    step("ex5");
    chk("ex5_ready", 0, 128'(s_ex_rdy[0]), 128'(1));
    chk("ex5_ven", 0, 128'(v_en[0]), 128'(4'b1111));
    chk("ex5_pend5", 0, 128'(pend[0]), 128'(32'h0000_0020));
    ex_valid = 1'b0;
    step("idle");

    // Both valid every cycle: load every 4th cycle at STARVE_MAX=3, every cycle at 0.
    ex_valid = 1'b1;
    ld_valid = 1'b1;
    ex_addr  = 5'd2;
    ex_mask  = 4'b0011;
    ld_addr  = 5'd9;
    ld_mask  = 4'b0101;
    ld_cnt0  = 0;
    ld_cnt1  = 0;
    ex_cnt0  = 0;
    for (int i = 0; i < 12; i++) begin
      ex_data = {$urandom, $urandom, $urandom, $urandom};
      ld_data = {$urandom, $urandom, $urandom, $urandom};
      step("both");
      chk("both_ld_pattern", 0, 128'(s_ld_rdy[0]), 128'((i % 4) == 3));
      ld_cnt0 += int'(s_ld_rdy[0]);
      ld_cnt1 += int'(s_ld_rdy[1]);
      ex_cnt0 += int'(s_ex_rdy[0]);
    end
    chk("both_ld_count", 0, 128'(ld_cnt0), 128'(3));
    chk("both_ex_count", 0, 128'(ex_cnt0), 128'(9));
    chk("strict_ld_count", 1, 128'(ld_cnt1), 128'(12));

    // Zero-mask load is consumed without writing.
    ex_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 5'd12;
    ld_mask  = 4'b0000;
    step("ld_zero");
    chk("ld_zero_ready", 0, 128'(s_ld_rdy[0]), 128'(1));
    chk("ld_zero_elen", 0, 128'(el_en[0]), 128'(0));
    chk("ld_zero_pend", 0, 128'(pend[0]), 128'(0));

    // Granted write is dropped when reset arrives on the following edge.
    ld_valid = 1'b0;
    ex_valid = 1'b1;
    ex_addr  = 5'd20;
    ex_mask  = 4'hf;
    step("pre_rst");
    rstn = 1'b0;
    step("rst_drop");
    chk("rst_drop_ven", 0, 128'(v_en[0]), 128'(0));
    chk("rst_drop_addr", 0, 128'(v_addr[0]), 128'(0));
    chk("rst_drop_pend", 0, 128'(pend[0]), 128'(0));
    rstn = 1'b1;

    // Same register, disjoint masks.
    ex_valid = 1'b1;
    ld_valid = 1'b1;
    ex_addr  = 5'd7;
    ld_addr  = 5'd7;
    ex_mask  = 4'b0011;
    ld_mask  = 4'b1100;
    step("merge");
`ifdef CELLRV32_VRF_WR_MERGE_EN
    chk("merge_ven", 0, 128'(v_en[0]), 128'(4'b0011));
    chk("merge_elen", 0, 128'(el_en[0]), 128'(4'b1100));
    ld_mask = 4'b0110;
    step("overlap");
    chk("overlap_elen", 0, 128'(el_en[0]), 128'(0));
`endif

    for (int i = 0; i < 400; i++) begin
      rstn     = ($urandom_range(0, 39) != 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      ld_valid = ($urandom_range(0, 3) != 0);
      ex_addr  = 5'($urandom_range(0, 7));
      ld_addr  = 5'($urandom_range(0, 7));
      ex_mask  = 4'($urandom);
      ld_mask  = 4'($urandom);
      ex_data  = {$urandom, $urandom, $urandom, $urandom};
      ld_data  = {$urandom, $urandom, $urandom, $urandom};
      step("rand");
`ifndef CELLRV32_VRF_WR_MERGE_EN
      for (int k = 0; k < 2; k++) begin
        chk("rand_one_writer", k, 128'((|v_en[k]) & (|el_en[k])), 128'(0));
      end
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
